fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: byte address of the first fetch after reset.
REQ-002 Parameter NOP_WORD, default 32'hE000_0000: bubble word inserted into the IF/ID register.
REQ-003 Parameter HALT_WORD, default 32'hEAFF_FFFF: branch-to-self encoding (B #-1) that triggers halt.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 freeze  input  1  hazard stall; holds the PC and the IF/ID register.
REQ-007 flush  input  1  replaces the IF/ID contents with a bubble.
REQ-008 branch_taken  input  1  redirects the PC to branch_addr.
REQ-009 branch_addr  input  32  branch target byte address.
REQ-010 imem_addr  output  32  address to the combinational instruction memory; equals the PC register.
REQ-011 imem_data  input  32  instruction word returned in the same cycle as imem_addr.
REQ-012 instr_out  output  32  IF/ID instruction.
REQ-013 pc_out  output  32  IF/ID PC+4 of instr_out.
REQ-014 valid_out  output  1  IF/ID instruction is real, not a bubble.
REQ-015 halted  output  1  high while the FSM is in HALT.

Function
REQ-016 The PC update priority per cycle SHALL be: rst > HALT hold > branch_taken > freeze > PC+4.
REQ-017 On branch_taken (FSM in RUN), the PC SHALL load {branch_addr[31:2],2'b00}, with bits [1:0] forced to zero regardless of freeze.
REQ-018 PC+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000) and SHALL NOT raise any flag.
REQ-019 The IF/ID update priority SHALL be: rst > (flush or branch_taken or HALT) -> bubble > freeze -> hold > load.
REQ-020 A bubble SHALL set instr_out=NOP_WORD, pc_out=0, valid_out=0.
REQ-021 A load SHALL set instr_out=imem_data, pc_out=PC+4, valid_out=1, with 1-cycle latency from imem_addr to instr_out.
REQ-022 When flush and freeze are both asserted, flush SHALL win for IF/ID while the PC holds.
REQ-023 The FSM SHALL have two states, RUN and HALT.
REQ-024 RUN->HALT SHALL occur on a load cycle in which imem_data==HALT_WORD; the halt word itself SHALL be loaded into IF/ID with valid_out=1.
REQ-025 In HALT, the PC SHALL hold, IF/ID SHALL take bubbles every cycle, branch_taken and freeze SHALL be ignored, and halted SHALL be 1.
REQ-026 HALT SHALL be exited only by rst.
REQ-027 HALT_WORD arriving during a freeze, flush or branch_taken cycle SHALL NOT trigger halt.

Reset
REQ-028 A rst sampled high SHALL set PC=RESET_PC, instr_out=NOP_WORD, pc_out=0, valid_out=0, halted=0 and FSM=RUN, overriding every other input including mid-halt and mid-stall.
REQ-029 The first load SHALL occur on the first edge with rst low and SHALL fetch RESET_PC.

Configuration
REQ-030 With macro FETCH_STATS_EN defined, the block SHALL add outputs fetch_count[31:0] (increments on each load) and bubble_count[31:0] (increments on each bubble cycle outside reset); both SHALL be saturating, reset to 0, and frozen in HALT except that bubble_count keeps counting.
REQ-031 Without FETCH_STATS_EN, the counters and their ports SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-032 Reset, then 3 free-running cycles with imem_data=A,B,C -> imem_addr 0,4,8,12; pc_out 4,8,12; valid_out=1.
REQ-033 freeze high for 2 cycles at PC=8 -> imem_addr stays 8; instr_out/pc_out unchanged; resumes at 12 after release.
REQ-034 branch_taken with branch_addr=32'h0000_0093 and freeze=1 -> next imem_addr=32'h90; IF/ID bubble (NOP_WORD, valid_out=0).
REQ-035 imem_data=32'hEAFF_FFFF at PC=0xB8 -> instr_out=EAFFFFFF, valid_out=1, then halted=1, imem_addr stuck at 0xB8; a later branch_taken to 0 is ignored; rst returns PC to 0.
REQ-036 PC preloaded to 32'hFFFF_FFFC by branch -> next imem_addr=0, halted=0.
REQ-037 With FETCH_STATS_EN: 5 loads, 1 flush, 2 freeze cycles -> fetch_count=5, bubble_count=1.

Source files
------------

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, IF/ID register and RUN/HALT FSM.
// Optional fetch/bubble statistics counters are enabled with FETCH_STATS_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD  = 32'hE000_0000,
  parameter logic [31:0] HALT_WORD = 32'hEAFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic        valid_out,
  output logic        halted
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] bubble_count
`endif
);

  typedef enum logic {ST_RUN, ST_HALT} state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_pc_out;
  logic        r_valid;
  logic        r_halted;

  logic [31:0] w_pc_plus4;
  logic        w_bubble;
  logic        w_load;
  logic        w_halt_hit;

  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_bubble   = (r_state == ST_HALT) | flush | branch_taken;
  assign w_load     = (r_state == ST_RUN) & ~flush & ~branch_taken & ~freeze;
  // The halt word is captured but the PC parks on it rather than advancing.
  assign w_halt_hit = w_load & (imem_data == HALT_WORD);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_RUN;
      r_pc     <= RESET_PC;
      r_instr  <= NOP_WORD;
      r_pc_out <= 32'd0;
      r_valid  <= 1'b0;
      r_halted <= 1'b0;
    end else begin
      if (r_state == ST_RUN) begin
        if (branch_taken) begin
          r_pc <= branch_addr & ~32'h3;
        end else if (!freeze && !w_halt_hit) begin
          r_pc <= w_pc_plus4;
        end
      end

      if (w_bubble) begin
        r_instr  <= NOP_WORD;
        r_pc_out <= 32'd0;
        r_valid  <= 1'b0;
      end else if (w_load) begin
        r_instr  <= imem_data;
        r_pc_out <= w_pc_plus4;
        r_valid  <= 1'b1;
      end

      if (w_halt_hit) begin
        r_state  <= ST_HALT;
        r_halted <= 1'b1;
      end
    end
  end

  assign imem_addr = r_pc;
  assign instr_out = r_instr;
  assign pc_out    = r_pc_out;
  assign valid_out = r_valid;
  assign halted    = r_halted;

`ifdef FETCH_STATS_EN
  logic [31:0] r_fetch_count;
  logic [31:0] r_bubble_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_count  <= 32'd0;
      r_bubble_count <= 32'd0;
    end else begin
      if (w_load && (r_fetch_count != 32'hFFFF_FFFF)) begin
        r_fetch_count <= r_fetch_count + 32'd1;
      end
      if (w_bubble && (r_bubble_count != 32'hFFFF_FFFF)) begin
        r_bubble_count <= r_bubble_count + 32'd1;
      end
    end
  end

  assign fetch_count  = r_fetch_count;
  assign bubble_count = r_bubble_count;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit (stats checked when FETCH_STATS_EN is defined).
module tb_fetch_unit;

  localparam logic [31:0] NOP  = 32'hE000_0000;
  localparam logic [31:0] HALT = 32'hEAFF_FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        freeze = 1'b0;
  logic        flush = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_addr = 32'd0;
  logic [31:0] imem_addr;
  logic [31:0] imem_data = 32'd0;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic        valid_out;
  logic        halted;
`ifdef FETCH_STATS_EN
  logic [31:0] fetch_count;
  logic [31:0] bubble_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        rs;
    logic        fr;
    logic        fl;
    logic        br;
    logic [31:0] ba;
    logic [31:0] data;
  } stim_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        valid;
    logic        halt;
  } exp_t;

  stim_t stim_q[$];
  exp_t  sb_q[$];

  fetch_unit dut (
    .clk          (clk),
    .rst          (rst),
    .freeze       (freeze),
    .flush        (flush),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .imem_addr    (imem_addr),
    .imem_data    (imem_data),
    .instr_out    (instr_out),
    .pc_out       (pc_out),
    .valid_out    (valid_out),
    .halted       (halted)
`ifdef FETCH_STATS_EN
    ,
    .fetch_count  (fetch_count),
    .bubble_count (bubble_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push(input logic rs, input logic fr, input logic fl, input logic br,
                      input logic [31:0] ba, input logic [31:0] data,
                      input logic [31:0] ea, input logic [31:0] ei, input logic [31:0] ep,
                      input logic ev, input logic eh);
    stim_t s;
    exp_t  e;
    s.rs = rs; s.fr = fr; s.fl = fl; s.br = br; s.ba = ba; s.data = data;
    e.addr = ea; e.instr = ei; e.pc = ep; e.valid = ev; e.halt = eh;
    stim_q.push_back(s);
    sb_q.push_back(e);
  endtask

  task automatic drive(input stim_t s);
    rst = s.rs; freeze = s.fr; flush = s.fl; branch_taken = s.br;
    branch_addr = s.ba; imem_data = s.data;
  endtask

  task automatic test_reset();
    stim_t s;
    exp_t  e;
    int    k = 0;
    // Reset must win over stall, flush and branch inputs.
    push(1, 1, 1, 1, 32'h40, HALT, 32'h0, NOP, 32'h0, 0, 0);
    push(1, 0, 0, 0, 32'h0,  32'h0, 32'h0, NOP, 32'h0, 0, 0);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      drive(s);
      tick();
      e = sb_q.pop_front();
      n_checks++;
      if ({imem_addr, instr_out, pc_out, valid_out, halted} !== {e.addr, e.instr, e.pc, e.valid, e.halt}) begin
        n_fail++;
        $display("FAIL reset[%0d]: got addr=%h instr=%h pc=%h v=%b h=%b, want addr=%h instr=%h pc=%h v=%b h=%b",
                 k, imem_addr, instr_out, pc_out, valid_out, halted, e.addr, e.instr, e.pc, e.valid, e.halt);
      end
      k++;
    end
  endtask

  task automatic test_run_freeze();
    stim_t s;
    exp_t  e;
    int    k = 0;
    push(0, 0, 0, 0, 0, 32'hAAAA_0001, 32'h4,  32'hAAAA_0001, 32'h4,  1, 0);
    push(0, 0, 0, 0, 0, 32'hBBBB_0002, 32'h8,  32'hBBBB_0002, 32'h8,  1, 0);
    push(0, 1, 0, 0, 0, 32'h1111_1111, 32'h8,  32'hBBBB_0002, 32'h8,  1, 0);
    push(0, 1, 0, 0, 0, HALT,          32'h8,  32'hBBBB_0002, 32'h8,  1, 0);
    push(0, 0, 0, 0, 0, 32'hCCCC_0003, 32'hC,  32'hCCCC_0003, 32'hC,  1, 0);
    push(0, 0, 0, 0, 0, 32'hDDDD_0004, 32'h10, 32'hDDDD_0004, 32'h10, 1, 0);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      drive(s);
      tick();
      e = sb_q.pop_front();
      n_checks++;
      if ({imem_addr, instr_out, pc_out, valid_out, halted} !== {e.addr, e.instr, e.pc, e.valid, e.halt}) begin
        n_fail++;
        $display("FAIL run_freeze[%0d]: got addr=%h instr=%h pc=%h v=%b h=%b, want addr=%h instr=%h pc=%h v=%b h=%b",
                 k, imem_addr, instr_out, pc_out, valid_out, halted, e.addr, e.instr, e.pc, e.valid, e.halt);
      end
      k++;
    end
  endtask

  task automatic test_branch_flush();
    stim_t s;
    exp_t  e;
    int    k = 0;
    push(0, 1, 0, 1, 32'h0000_0093, 32'hDEAD_0001, 32'h90, NOP, 32'h0, 0, 0);
    push(0, 0, 0, 0, 0, 32'hEEEE_0005, 32'h94, 32'hEEEE_0005, 32'h94, 1, 0);
    push(0, 1, 1, 0, 0, 32'h1234_5678, 32'h94, NOP, 32'h0, 0, 0);
    push(0, 0, 1, 0, 0, HALT,          32'h98, NOP, 32'h0, 0, 0);
    push(0, 0, 0, 0, 0, 32'hFFFF_0006, 32'h9C, 32'hFFFF_0006, 32'h9C, 1, 0);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      drive(s);
      tick();
      e = sb_q.pop_front();
      n_checks++;
      if ({imem_addr, instr_out, pc_out, valid_out, halted} !== {e.addr, e.instr, e.pc, e.valid, e.halt}) begin
        n_fail++;
        $display("FAIL branch_flush[%0d]: got addr=%h instr=%h pc=%h v=%b h=%b, want addr=%h instr=%h pc=%h v=%b h=%b",
                 k, imem_addr, instr_out, pc_out, valid_out, halted, e.addr, e.instr, e.pc, e.valid, e.halt);
      end
      k++;
    end
  endtask

  task automatic test_halt();
    stim_t s;
    exp_t  e;
    int    k = 0;
    push(0, 0, 0, 1, 32'hB8, HALT, 32'hB8, NOP, 32'h0, 0, 0);
    push(0, 1, 0, 0, 0, HALT, 32'hB8, NOP, 32'h0, 0, 0);
    push(0, 0, 0, 0, 0, HALT, 32'hB8, HALT, 32'hBC, 1, 1);
    push(0, 1, 0, 1, 32'h0, 32'h0000_0001, 32'hB8, NOP, 32'h0, 0, 1);
    push(0, 0, 0, 0, 0, 32'h0000_0002, 32'hB8, NOP, 32'h0, 0, 1);
    push(1, 0, 0, 0, 0, 32'h0000_0003, 32'h0, NOP, 32'h0, 0, 0);
    push(0, 0, 0, 0, 0, 32'h5555_0007, 32'h4, 32'h5555_0007, 32'h4, 1, 0);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      drive(s);
      tick();
      e = sb_q.pop_front();
      n_checks++;
      if ({imem_addr, instr_out, pc_out, valid_out, halted} !== {e.addr, e.instr, e.pc, e.valid, e.halt}) begin
        n_fail++;
        $display("FAIL halt[%0d]: got addr=%h instr=%h pc=%h v=%b h=%b, want addr=%h instr=%h pc=%h v=%b h=%b",
                 k, imem_addr, instr_out, pc_out, valid_out, halted, e.addr, e.instr, e.pc, e.valid, e.halt);
      end
      k++;
    end
  endtask

  task automatic test_wrap();
    stim_t s;
    exp_t  e;
    int    k = 0;
    push(0, 0, 0, 1, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFC, NOP, 32'h0, 0, 0);
    push(0, 0, 0, 0, 0, 32'h7777_0008, 32'h0, 32'h7777_0008, 32'h0, 1, 0);
    push(0, 0, 0, 0, 0, 32'h8888_0009, 32'h4, 32'h8888_0009, 32'h4, 1, 0);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      drive(s);
      tick();
      e = sb_q.pop_front();
      n_checks++;
      if ({imem_addr, instr_out, pc_out, valid_out, halted} !== {e.addr, e.instr, e.pc, e.valid, e.halt}) begin
        n_fail++;
        $display("FAIL wrap[%0d]: got addr=%h instr=%h pc=%h v=%b h=%b, want addr=%h instr=%h pc=%h v=%b h=%b",
                 k, imem_addr, instr_out, pc_out, valid_out, halted, e.addr, e.instr, e.pc, e.valid, e.halt);
      end
      k++;
    end
  endtask

`ifdef FETCH_STATS_EN
  task automatic test_stats();
    stim_t s;
    logic [31:0] exp_f[$];
    logic [31:0] exp_b[$];
    logic [31:0] ef;
    logic [31:0] eb;
    push(1, 0, 0, 0, 0, 32'h0, 32'h0,  NOP, 32'h0, 0, 0); exp_f.push_back(0); exp_b.push_back(0);
    push(0, 0, 0, 0, 0, 32'h1, 32'h4,  32'h1, 32'h4, 1, 0); exp_f.push_back(1); exp_b.push_back(0);
    push(0, 0, 0, 0, 0, 32'h2, 32'h8,  32'h2, 32'h8, 1, 0); exp_f.push_back(2); exp_b.push_back(0);
    push(0, 1, 0, 0, 0, 32'h3, 32'h8,  32'h2, 32'h8, 1, 0); exp_f.push_back(2); exp_b.push_back(0);
    push(0, 1, 0, 0, 0, 32'h3, 32'h8,  32'h2, 32'h8, 1, 0); exp_f.push_back(2); exp_b.push_back(0);
    push(0, 0, 0, 0, 0, 32'h3, 32'hC,  32'h3, 32'hC, 1, 0); exp_f.push_back(3); exp_b.push_back(0);
    push(0, 0, 1, 0, 0, 32'h4, 32'h10, NOP, 32'h0, 0, 0);   exp_f.push_back(3); exp_b.push_back(1);
    push(0, 0, 0, 0, 0, 32'h5, 32'h14, 32'h5, 32'h14, 1, 0); exp_f.push_back(4); exp_b.push_back(1);
    push(0, 0, 0, 0, 0, 32'h6, 32'h18, 32'h6, 32'h18, 1, 0); exp_f.push_back(5); exp_b.push_back(1);
    sb_q.delete();
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      drive(s);
      tick();
      ef = exp_f.pop_front();
      eb = exp_b.pop_front();
      n_checks++;
      if ({fetch_count, bubble_count} !== {ef, eb}) begin
        n_fail++;
        $display("FAIL stats: got fetch=%0d bubble=%0d, want fetch=%0d bubble=%0d",
                 fetch_count, bubble_count, ef, eb);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_run_freeze();
    test_branch_flush();
    test_halt();
    test_wrap();
`ifdef FETCH_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
